im_loader: RTL and testbench

//   Serial boot loader: the write side of the instruction memory, which the core only reads.
//   - Accepts a framed byte stream from a UART receiver over a valid/ready handshake.
//   - Assembles the bytes into 32-bit instruction words and drives the IM write port.
//   - Holds the CPU stalled while an image is loading, then releases it when the load completes.

---
 rtl/im_loader.sv | 148 ++++++++++++++
 tb/tb_im_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Serial boot loader: frames a UART byte stream into 32-bit words for the instruction memory
// and keeps the CPU stalled until a complete, checksum-verified image has been written.
module im_loader #(
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_wr,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]     MAX_N     = 17'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [7:0]        checksum;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [1:0]        lane;
    logic [23:0]       word_lo;
    logic [TW-1:0]     timer;

    logic        accept;
    logic [15:0] n_words;
    logic        in_frame;

    assign accept   = rx_valid & rx_ready;
    assign n_words  = {rx_data, len_lo};
    assign in_frame = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b1;
            im_wr     <= 1'b0;
            im_addr   <= '0;
            im_data   <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            checksum  <= '0;
            timer     <= '0;
            len_lo    <= '0;
            idx       <= '0;
            last_idx  <= '0;
            lane      <= '0;
            word_lo   <= '0;
        end else begin
            // The write strobe and the back-pressure it causes last exactly one cycle.
            im_wr    <= 1'b0;
            rx_ready <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept && rx_data == MAGIC) begin
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        checksum  <= '0;
                        idx       <= '0;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= rx_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        if (n_words == 16'd0 || {1'b0, n_words} > MAX_N) begin
                            state <= S_ERROR;
                        end else begin
                            last_idx <= ADDR_W'(n_words - 16'd1);
                            lane     <= '0;
                            state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (im_wr) begin
                        idx <= idx + 1'b1;
                        if (idx == last_idx) state <= S_CSUM;
                    end else if (accept) begin
                        checksum <= checksum ^ rx_data;
                        lane     <= lane + 2'd1;
                        case (lane)
                            2'd0: word_lo[7:0]   <= rx_data;
                            2'd1: word_lo[15:8]  <= rx_data;
                            2'd2: word_lo[23:16] <= rx_data;
                            default: begin
                                im_wr    <= 1'b1;
                                rx_ready <= 1'b0;
                                im_addr  <= idx;
                                im_data  <= {rx_data, word_lo};
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (accept) state <= (rx_data == checksum) ? S_DONE : S_ERROR;
                end
                S_DONE: begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    // cpu_hold is deliberately left set: a partially loaded image must not run.
                    load_err <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase

            // Inter-byte watchdog; overrides whatever transition the frame logic chose.
            if (in_frame) begin
                if (accept) begin
                    timer <= '0;
                end else if (timer == TIMER_MAX) begin
                    timer <= '0;
                    state <= S_ERROR;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: expected IM writes and frame outcomes are queued by the
// stimulus and popped by an independent monitor whenever the DUT strobes them.
module tb_im_loader;

    localparam int ADDR_W      = 10;
    localparam int TIMEOUT_CYC = 100;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_wr;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    im_loader #(
        .ADDR_W      (ADDR_W),
        .MAGIC       (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .im_wr     (im_wr),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    // Handshake: a byte transfers on a rising edge where rx_valid and rx_ready are both high.

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+31:0] exp_q[$];   // {addr, data} of each expected IM write
    logic [2:0]         res_q[$];   // {load_done, load_err, cpu_hold} at each frame outcome
    logic               prev_flag = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_flag = 1'b0;
        end else begin
            chk("rx_ready_vs_im_wr", {63'd0, rx_ready}, {63'd0, ~im_wr});
            if (im_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_im_wr: got addr 0x%0h data 0x%0h expected no write",
                             im_addr, im_data);
                end else begin
                    logic [ADDR_W+31:0] e;
                    e = exp_q.pop_front();
                    chk("im_addr", 64'(im_addr), 64'(e[ADDR_W+31:32]));
                    chk("im_data", 64'(im_data), 64'(e[31:0]));
                end
            end
            if ((load_done || load_err) && !prev_flag) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_outcome: got done/err/hold %b expected none",
                             {load_done, load_err, cpu_hold});
                end else begin
                    logic [2:0] r;
                    r = res_q.pop_front();
                    chk("outcome_done_err_hold", 64'({load_done, load_err, cpu_hold}), 64'(r));
                end
            end
            prev_flag = load_done || load_err;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns just after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        bit taken;
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        taken    = 1'b0;
        n        = 0;
        while (!taken) begin
            @(negedge clk);
            taken = rx_ready;
            @(posedge clk);
            #1;
            n++;
            if (!taken && n > 50) begin
                checks++;
                failures++;
                $display("FAIL byte_accept_timeout: byte 0x%0h not taken after %0d cycles, expected acceptance", b, n);
                taken = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit b2b);
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (!b2b) idle(1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic expect_frame1_writes();
        exp_q.push_back({10'd0, 32'h1234_5678});
        exp_q.push_back({10'd1, 32'hDEAD_BEEF});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"},  64'(rx_ready),  64'd1);
        chk({tag, "_im_wr"},     64'(im_wr),     64'd0);
        chk({tag, "_im_addr"},   64'(im_addr),   64'd0);
        chk({tag, "_im_data"},   64'(im_data),   64'd0);
        chk({tag, "_cpu_hold"},  64'(cpu_hold),  64'd0);
        chk({tag, "_load_done"}, 64'(load_done), 64'd0);
        chk({tag, "_load_err"},  64'(load_err),  64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] frame1[$] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    logic [7:0] frame_bad[$] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    logic [7:0] junk[$]      = '{8'h00, 8'hFF, 8'h3C};
    logic [7:0] len_zero[$]  = '{8'hA5, 8'h00, 8'h00};
    logic [7:0] len_big[$]   = '{8'hA5, 8'h01, 8'h04};
    logic [7:0] partial[$]   = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    logic [7:0] cut[$]       = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};

    initial begin
        int n;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Junk before MAGIC is swallowed, then a good frame loads.
        send_frame(junk, 1'b0);
        chk("junk_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("junk_load_done", 64'(load_done), 64'd0);
        expect_frame1_writes();
        res_q.push_back(3'b100);
        send_frame(frame1, 1'b0);
        idle(4);
        chk("frame1_load_done", 64'(load_done), 64'd1);
        chk("frame1_cpu_hold", 64'(cpu_hold), 64'd0);

        // Same frame with rx_valid held high throughout.
        expect_frame1_writes();
        res_q.push_back(3'b100);
        send_frame(frame1, 1'b1);
        idle(4);

        // Bad checksum: words still land, CPU stays held.
        expect_frame1_writes();
        res_q.push_back(3'b011);
        send_frame(frame_bad, 1'b0);
        idle(4);
        chk("badcsum_cpu_hold", 64'(cpu_hold), 64'd1);

        // Zero and oversize lengths.
        res_q.push_back(3'b011);
        send_frame(len_zero, 1'b0);
        idle(3);
        res_q.push_back(3'b011);
        send_frame(len_big, 1'b0);
        idle(3);

        // Stall mid-word: timeout fires after TIMEOUT_CYC idle cycles (+1 for the error state).
        res_q.push_back(3'b011);
        foreach (partial[i]) begin
            send_byte(partial[i]);
            if (i != partial.size() - 1) idle(1);
        end
        rx_valid = 1'b0;
        n = 0;
        while (!load_err && n < 2 * TIMEOUT_CYC) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(n == TIMEOUT_CYC || n == TIMEOUT_CYC + 1)) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", n,
                     TIMEOUT_CYC, TIMEOUT_CYC + 1);
        end
        idle(3);

        // Reset mid-frame after the 6th data byte, then a clean load.
        exp_q.push_back({10'd0, 32'h1234_5678});
        send_frame(cut, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk("midrst_hold_im_wr", 64'(im_wr), 64'd0);
        rst = 1'b0;
        idle(2);
        expect_frame1_writes();
        res_q.push_back(3'b100);
        send_frame(frame1, 1'b0);
        idle(4);
        chk("after_rst_load_done", 64'(load_done), 64'd1);
        chk("after_rst_load_err", 64'(load_err), 64'd0);

        idle(5);
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
        chk("outcomes_outstanding", 64'(res_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
